// File: rtl/pc_update_ctrl.sv
// pc_update_ctrl: next-PC sequencer for the multicycle datapath.
// Drives the PC-source mux select and PC write strobe, and runs exception
// entry (EPC save, vector byte read, PC load).
// Optional macro PC_CAUSE_REG_EN adds the cause / exc_pending outputs.
// Ports:
//   clk, reset (async, active-high)
//   req_valid/req_ready, req_kind, exc_code, alu_zero : request side
//   pc_source, pc_write, epc_write, jump_src_vec      : datapath controls
//   mem_rd, vec_addr, mem_data                        : vector read
//   vec_target (zero-extended handler address), busy_exc
module pc_update_ctrl #(
    parameter logic [7:0] VEC_BASE = 8'd253,
    parameter int         MEM_LAT  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [2:0]  req_kind,
    input  logic [1:0]  exc_code,
    input  logic        alu_zero,
    input  logic [7:0]  mem_data,
    output logic        req_ready,
    output logic [1:0]  pc_source,
    output logic        pc_write,
    output logic        epc_write,
    output logic        mem_rd,
    output logic [7:0]  vec_addr,
    output logic [31:0] vec_target,
    output logic        jump_src_vec,
    output logic        busy_exc
`ifdef PC_CAUSE_REG_EN
    ,
    output logic [1:0]  cause,
    output logic        exc_pending
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        EXC_EPC,
        EXC_RD,
        EXC_WAIT,
        EXC_LOAD,
        EXC_ISSUE
    } state_t;

    localparam logic [2:0] K_SEQ  = 3'd0;
    localparam logic [2:0] K_BEQ  = 3'd1;
    localparam logic [2:0] K_BNE  = 3'd2;
    localparam logic [2:0] K_JUMP = 3'd3;
    localparam logic [2:0] K_JR   = 3'd4;
    localparam logic [2:0] K_RTE  = 3'd5;
    localparam logic [2:0] K_EXC  = 3'd6;

    state_t      state, state_n;
    logic [2:0]  kind_q, kind_n;
    logic        zero_q, zero_n;
    logic [1:0]  code_q, code_n;
    logic [2:0]  cnt_q, cnt_n;

    logic        ready_n, pcw_n, epcw_n, rd_n, jsv_n, busy_n;
    logic [1:0]  src_n;
    logic [7:0]  addr_n;
    logic [31:0] tgt_n;
`ifdef PC_CAUSE_REG_EN
    logic [1:0]  cause_n;
    logic        pend_n;
`endif

    // Next state and request latching.
    always_comb begin
        state_n = state;
        kind_n  = kind_q;
        zero_n  = zero_q;
        code_n  = code_q;
        cnt_n   = cnt_q;
        tgt_n   = vec_target;
`ifdef PC_CAUSE_REG_EN
        cause_n = cause;
        pend_n  = exc_pending;
`endif
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    kind_n = req_kind;
                    zero_n = alu_zero;
                    if (req_kind[2] & req_kind[1]) begin
                        // Reserved kind 111 and reserved cause 11
                        // both collapse onto invalid opcode.
                        kind_n  = K_EXC;
                        code_n  = (req_kind[0] || exc_code == 2'b11)
                                  ? 2'b00 : exc_code;
                        state_n = EXC_EPC;
                    end else begin
                        state_n = ISSUE;
                    end
                end
            end
            ISSUE: begin
`ifdef PC_CAUSE_REG_EN
                if (kind_q == K_RTE)
                    pend_n = 1'b0;
`endif
                state_n = IDLE;
            end
            EXC_EPC: begin
`ifdef PC_CAUSE_REG_EN
                cause_n = code_q;
                pend_n  = 1'b1;
`endif
                state_n = EXC_RD;
            end
            EXC_RD: begin
                if (MEM_LAT > 1) begin
                    cnt_n   = 3'(MEM_LAT - 1);
                    state_n = EXC_WAIT;
                end else begin
                    state_n = EXC_LOAD;
                end
            end
            EXC_WAIT: begin
                if (cnt_q <= 3'd1)
                    state_n = EXC_LOAD;
                else
                    cnt_n = cnt_q - 3'd1;
            end
            EXC_LOAD: begin
                tgt_n   = {24'b0, mem_data};
                state_n = EXC_ISSUE;
            end
            EXC_ISSUE: state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    // Registered outputs are decoded from the state being entered.
    always_comb begin
        ready_n = 1'b0;
        src_n   = 2'b00;
        pcw_n   = 1'b0;
        epcw_n  = 1'b0;
        rd_n    = 1'b0;
        jsv_n   = 1'b0;
        busy_n  = 1'b0;
        addr_n  = vec_addr;
        unique case (state_n)
            IDLE: ready_n = 1'b1;
            ISSUE: begin
                unique case (kind_n)
                    K_SEQ: begin
                        src_n = 2'b00;
                        pcw_n = 1'b1;
                    end
                    K_BEQ: begin
                        src_n = 2'b01;
                        pcw_n = zero_n;
                    end
                    K_BNE: begin
                        src_n = 2'b01;
                        pcw_n = ~zero_n;
                    end
                    K_JUMP: begin
                        src_n = 2'b10;
                        pcw_n = 1'b1;
                    end
                    K_JR: begin
                        src_n = 2'b00;
                        pcw_n = 1'b1;
                    end
                    K_RTE: begin
                        src_n = 2'b11;
                        pcw_n = 1'b1;
                    end
                    default: begin
                        src_n = 2'b00;
                        pcw_n = 1'b0;
                    end
                endcase
            end
            EXC_EPC: begin
                busy_n = 1'b1;
                epcw_n = 1'b1;
            end
            EXC_RD: begin
                busy_n = 1'b1;
                rd_n   = 1'b1;
                addr_n = VEC_BASE + {6'b0, code_n};
            end
            EXC_WAIT: busy_n = 1'b1;
            EXC_LOAD: busy_n = 1'b1;
            EXC_ISSUE: begin
                busy_n = 1'b1;
                src_n  = 2'b10;
                jsv_n  = 1'b1;
                pcw_n  = 1'b1;
            end
            default: ready_n = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            kind_q       <= 3'd0;
            zero_q       <= 1'b0;
            code_q       <= 2'd0;
            cnt_q        <= 3'd0;
            req_ready    <= 1'b1;
            pc_source    <= 2'b00;
            pc_write     <= 1'b0;
            epc_write    <= 1'b0;
            mem_rd       <= 1'b0;
            vec_addr     <= 8'd0;
            vec_target   <= 32'd0;
            jump_src_vec <= 1'b0;
            busy_exc     <= 1'b0;
`ifdef PC_CAUSE_REG_EN
            cause        <= 2'd0;
            exc_pending  <= 1'b0;
`endif
        end else begin
            state        <= state_n;
            kind_q       <= kind_n;
            zero_q       <= zero_n;
            code_q       <= code_n;
            cnt_q        <= cnt_n;
            req_ready    <= ready_n;
            pc_source    <= src_n;
            pc_write     <= pcw_n;
            epc_write    <= epcw_n;
            mem_rd       <= rd_n;
            vec_addr     <= addr_n;
            vec_target   <= tgt_n;
            jump_src_vec <= jsv_n;
            busy_exc     <= busy_n;
`ifdef PC_CAUSE_REG_EN
            cause        <= cause_n;
            exc_pending  <= pend_n;
`endif
        end
    end

endmodule

// File: tb/tb_pc_update_ctrl.sv
// tb_pc_update_ctrl: randomized self-checking bench for pc_update_ctrl.
// Lane 0 runs MEM_LAT=1, lane 1 runs MEM_LAT=3; a per-lane memory model
// returns the vector byte exactly MEM_LAT cycles after mem_rd.
module tb_pc_update_ctrl;

    localparam logic [7:0] VB = 8'd253;

    logic clk;
    logic rst;

    logic        req_valid [2];
    logic [2:0]  req_kind  [2];
    logic [1:0]  exc_code  [2];
    logic        alu_zero  [2];
    logic        rdy       [2];
    logic [1:0]  src       [2];
    logic        pcw       [2];
    logic        epcw      [2];
    logic        mrd       [2];
    logic [7:0]  vaddr     [2];
    logic [31:0] vtgt      [2];
    logic        jsv       [2];
    logic        busy      [2];
`ifdef PC_CAUSE_REG_EN
    logic [1:0]  cause     [2];
    logic        pend      [2];
`endif

    logic [7:0]  mem [256];

    logic [31:0] m_vt    [2];
    logic [1:0]  m_cause [2];
    logic        m_pend  [2];

    int n_chk;
    int n_err;

    for (genvar g = 0; g < 2; g++) begin : g_lane
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [7:0] hist;
        logic [7:0] rd_addr;
        logic [7:0] md;

        // Data is only correct in the single cycle it is due.
        assign md = hist[LAT-1] ? mem[rd_addr] : ~mem[rd_addr];

        always @(posedge clk) begin
            hist <= {hist[6:0], mrd[g]};
            if (mrd[g])
                rd_addr <= vaddr[g];
        end

        pc_update_ctrl #(
            .VEC_BASE (VB),
            .MEM_LAT  (LAT)
        ) u_dut (
            .clk          (clk),
            .reset        (rst),
            .req_valid    (req_valid[g]),
            .req_kind     (req_kind[g]),
            .exc_code     (exc_code[g]),
            .alu_zero     (alu_zero[g]),
            .mem_data     (md),
            .req_ready    (rdy[g]),
            .pc_source    (src[g]),
            .pc_write     (pcw[g]),
            .epc_write    (epcw[g]),
            .mem_rd       (mrd[g]),
            .vec_addr     (vaddr[g]),
            .vec_target   (vtgt[g]),
            .jump_src_vec (jsv[g]),
            .busy_exc     (busy[g])
`ifdef PC_CAUSE_REG_EN
            ,
            .cause        (cause[g]),
            .exc_pending  (pend[g])
`endif
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_cause(input int l);
`ifdef PC_CAUSE_REG_EN
        chk($sformatf("cause%0d", l), cause[l], m_cause[l]);
        chk($sformatf("pend%0d", l), pend[l], m_pend[l]);
`else
        chk($sformatf("vt_hold%0d", l), vtgt[l], m_vt[l]);
`endif
    endtask

    task automatic check_idle(input int l);
        chk($sformatf("idle_rdy%0d", l), rdy[l], 1);
        chk($sformatf("idle_busy%0d", l), busy[l], 0);
        chk($sformatf("idle_pcw%0d", l), pcw[l], 0);
        chk($sformatf("idle_epcw%0d", l), epcw[l], 0);
        chk($sformatf("idle_mrd%0d", l), mrd[l], 0);
        chk($sformatf("idle_jsv%0d", l), jsv[l], 0);
        chk($sformatf("idle_vt%0d", l), vtgt[l], m_vt[l]);
    endtask

    function automatic logic [1:0] exp_src(input logic [2:0] kind);
        case (kind)
            3'd1, 3'd2: return 2'b01;
            3'd3:       return 2'b10;
            3'd5:       return 2'b11;
            default:    return 2'b00;
        endcase
    endfunction

    function automatic logic exp_pcw(input logic [2:0] kind,
                                     input logic zero);
        case (kind)
            3'd1:    return zero;
            3'd2:    return ~zero;
            default: return 1'b1;
        endcase
    endfunction

    // One request from handshake to return to IDLE. abort_k > 0 asserts
    // reset in that cycle of the sequence.
    task automatic do_req(input int l, input logic [2:0] kind,
                          input logic [1:0] code, input logic zero,
                          input int abort_k);
        int lat;
        int n;
        int w;
        logic exc;
        logic [1:0] ec;
        logic [7:0] va;
        w = 0;
        while (!rdy[l] && w < 20) begin
            step();
            w++;
        end
        if (!rdy[l]) begin
            chk("ready_timeout", 0, 1);
            return;
        end
        req_valid[l] = 1'b1;
        req_kind[l]  = kind;
        exc_code[l]  = code;
        alu_zero[l]  = zero;
        lat = (l == 0) ? 1 : 3;
        exc = (kind >= 3'd6);
        ec  = (kind == 3'd7 || code == 2'd3) ? 2'd0 : code;
        va  = VB + {6'b0, ec};
        n   = exc ? 4 + lat : 2;
        for (int k = 1; k <= n; k++) begin
            step();
            if (!exc && k == 2 && kind == 3'd5)
                m_pend[l] = 1'b0;
            if (exc && k == 2) begin
                m_cause[l] = ec;
                m_pend[l]  = 1'b1;
            end
            if (exc && k == n - 1)
                m_vt[l] = {24'b0, mem[va]};
            if (k == n) begin
                check_idle(l);
            end else if (exc) begin
                chk($sformatf("x_rdy k%0d", k), rdy[l], 0);
                chk($sformatf("x_busy k%0d", k), busy[l], 1);
                chk($sformatf("x_epcw k%0d", k), epcw[l], k == 1);
                chk($sformatf("x_mrd k%0d", k), mrd[l], k == 2);
                chk($sformatf("x_pcw k%0d", k), pcw[l], k == n - 1);
                chk($sformatf("x_jsv k%0d", k), jsv[l], k == n - 1);
                if (k == n - 1)
                    chk("x_src", src[l], 2'b10);
                if (k >= 2 && k <= 1 + lat)
                    chk($sformatf("x_vaddr k%0d", k), vaddr[l], va);
                chk($sformatf("x_vt k%0d", k), vtgt[l], m_vt[l]);
            end else begin
                chk($sformatf("i_rdy kind%0d", kind), rdy[l], 0);
                chk($sformatf("i_busy kind%0d", kind), busy[l], 0);
                chk($sformatf("i_epcw kind%0d", kind), epcw[l], 0);
                chk($sformatf("i_mrd kind%0d", kind), mrd[l], 0);
                chk($sformatf("i_jsv kind%0d", kind), jsv[l], 0);
                chk($sformatf("i_src kind%0d", kind), src[l],
                    exp_src(kind));
                chk($sformatf("i_pcw kind%0d z%0d", kind, zero), pcw[l],
                    exp_pcw(kind, zero));
            end
            check_cause(l);
            if (k == abort_k) begin
                rst = 1'b1;
                req_valid[l] = 1'b0;
                #1;
                for (int j = 0; j < 2; j++) begin
                    m_vt[j]    = 32'd0;
                    m_cause[j] = 2'd0;
                    m_pend[j]  = 1'b0;
                end
                chk("rst_rdy", rdy[l], 1);
                chk("rst_busy", busy[l], 0);
                chk("rst_pcw", pcw[l], 0);
                chk("rst_mrd", mrd[l], 0);
                chk("rst_vaddr", vaddr[l], 0);
                chk("rst_vt", vtgt[l], 0);
                check_cause(l);
                step();
                step();
                rst = 1'b0;
                for (int j = 0; j < 4; j++) begin
                    step();
                    check_idle(l);
                end
                return;
            end
            if (k < n) begin
                req_valid[l] = 1'($urandom_range(0, 1));
                req_kind[l]  = 3'($urandom_range(0, 7));
                exc_code[l]  = 2'($urandom_range(0, 3));
                alu_zero[l]  = 1'($urandom_range(0, 1));
            end else begin
                req_valid[l] = 1'b0;
            end
        end
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst = 1'b1;
        for (int i = 0; i < 256; i++)
            mem[i] = 8'($urandom);
        mem[254] = 8'h7C;
        for (int j = 0; j < 2; j++) begin
            req_valid[j] = 1'b0;
            req_kind[j]  = 3'd0;
            exc_code[j]  = 2'd0;
            alu_zero[j]  = 1'b0;
            m_vt[j]      = 32'd0;
            m_cause[j]   = 2'd0;
            m_pend[j]    = 1'b0;
        end
        @(negedge clk);
        step();
        step();
        for (int j = 0; j < 2; j++) begin
            check_idle(j);
            chk("rst_src", src[j], 0);
            chk("rst_vaddr0", vaddr[j], 0);
            check_cause(j);
        end
        rst = 1'b0;
        step();

        do_req(0, 3'd0, 2'd0, 1'b0, 0);
        do_req(0, 3'd1, 2'd0, 1'b1, 0);
        do_req(0, 3'd1, 2'd0, 1'b0, 0);
        do_req(0, 3'd2, 2'd0, 1'b0, 0);
        do_req(0, 3'd2, 2'd0, 1'b1, 0);
        do_req(0, 3'd3, 2'd0, 1'b0, 0);
        do_req(0, 3'd4, 2'd0, 1'b0, 0);
        do_req(0, 3'd6, 2'd1, 1'b0, 0);
        chk("vt_7c", vtgt[0], 32'h0000007C);
        do_req(0, 3'd5, 2'd0, 1'b0, 0);
        do_req(1, 3'd6, 2'd3, 1'b0, 0);
        do_req(1, 3'd7, 2'd2, 1'b0, 0);
        do_req(1, 3'd6, 2'd2, 1'b0, 0);
        do_req(1, 3'd5, 2'd0, 1'b0, 0);
        do_req(1, 3'd6, 2'd3, 1'b0, 3);
        do_req(1, 3'd0, 2'd0, 1'b0, 0);
        do_req(0, 3'd6, 2'd2, 1'b0, 0);
        do_req(0, 3'd6, 2'd0, 1'b0, 0);

        for (int i = 0; i < 200; i++) begin
            int l;
            int gap;
            l = $urandom_range(0, 1);
            do_req(l, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 0);
            gap = $urandom_range(0, 2);
            for (int j = 0; j < gap; j++) begin
                step();
                check_idle(l);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/pc_update_ctrl.md
Name: pc_update_ctrl

Overview:
- Sequencer that drives the PC-source select and PC write-enable of the multicycle datapath.
- Takes a next-PC request from the main control unit and issues the mux select and write strobe.
- Runs the multi-cycle exception entry: EPC save, vector-byte fetch from memory, PC load.
- Pairs with the PC-source mux, whose select encoding is: 00 ALU result, 01 ALUOut, 10 jump address, 11 EPC.

Parameters:
- VEC_BASE, 8'd253, memory byte address of the first exception vector; the vector for a cause is at VEC_BASE + exc_code.
- MEM_LAT, 1, cycles from mem_rd assertion until mem_data is valid (1..7).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  next-PC request present.
- req_kind  input  3  request type: 000 seq, 001 beq, 010 bne, 011 jump, 100 jr, 101 rte, 110 exception; 111 is reserved.
- exc_code  input  2  exception cause: 00 invalid opcode, 01 overflow, 10 divide-by-zero; 11 is reserved.
- alu_zero  input  1  zero flag, sampled in the accept cycle.
- mem_data  input  8  byte returned by memory for a vector read.
- req_ready  output  1  block can accept a request.
- pc_source  output  2  select to the PC-source mux.
- pc_write  output  1  PC write enable, one-cycle pulse.
- epc_write  output  1  EPC write enable, one-cycle pulse; the datapath stores PC-4.
- mem_rd  output  1  vector read strobe.
- vec_addr  output  8  vector read address.
- vec_target  output  32  zero-extended handler address.
- jump_src_vec  output  1  steers vec_target onto the jump-address input of the PC-source mux.
- busy_exc  output  1  exception entry in progress.

Behaviour:
- Reset: asynchronous and active-high; while reset is asserted or on its rising edge the FSM enters IDLE.
  - All outputs are 0 after reset, except req_ready = 1.
  - vec_target and the latched request are cleared.
  - Reset asserted mid-sequence aborts it with no further pc_write or epc_write.
- All outputs are registered. A request is accepted on a rising edge with req_valid & req_ready. Requests are ignored while req_ready = 0; nothing is queued.
- States: IDLE, ISSUE, EXC_EPC, EXC_RD, EXC_WAIT, EXC_LOAD, EXC_ISSUE.
- IDLE: req_ready = 1.
  - Accept of kinds 000..101 -> ISSUE.
  - Accept of kind 110 -> EXC_EPC.
  - Accept of kind 111 -> treated as 110 with exc_code forced to 00 (invalid opcode).
- ISSUE (1 cycle), then back to IDLE:
  - seq: pc_source 00, pc_write 1.
  - beq: pc_source 01, pc_write = latched alu_zero.
  - bne: pc_source 01, pc_write = ~alu_zero.
  - jump: pc_source 10, pc_write 1.
  - jr: pc_source 00, pc_write 1.
  - rte: pc_source 11, pc_write 1.
  - req_ready is 0 in ISSUE, so back-to-back requests have a throughput of 1 every 2 cycles.
- Exception entry:
  - busy_exc = 1 in every EXC_* state; req_ready = 0 in every EXC_* state.
  - An exc_code of 11 is treated as 00.
  - EXC_EPC (1 cycle): epc_write 1 -> EXC_RD.
  - EXC_RD (1 cycle): mem_rd 1, vec_addr = VEC_BASE + exc_code (8-bit add, wraps mod 256) -> EXC_WAIT.
  - EXC_WAIT: lasts MEM_LAT-1 cycles, using a 3-bit down-counter; it is skipped when MEM_LAT = 1. vec_addr is held throughout.
  - EXC_LOAD (1 cycle): vec_target <= {24'b0, mem_data} -> EXC_ISSUE.
  - EXC_ISSUE (1 cycle): pc_source 10, jump_src_vec 1, pc_write 1 -> IDLE.
  - Total entry time is 4 + MEM_LAT cycles from accept.
- Outside their asserting states, pc_write, epc_write, mem_rd and jump_src_vec are 0.
- vec_target holds its value until the next exception entry.
- Simultaneous events: req_valid arriving during any non-IDLE state is dropped; the requester must hold it until it sees req_ready.

Optional Feature:
- Macro: PC_CAUSE_REG_EN.
- When defined:
  - Adds the output cause (2 bits) and the output exc_pending (1 bit).
  - In EXC_EPC, cause <= effective exc_code and exc_pending <= 1.
  - ISSUE of an rte clears exc_pending; cause is retained.
  - An exception accepted while exc_pending = 1 (nested fault) still runs the full entry sequence and overwrites cause.
  - Reset clears both.
- When undefined: neither port exists, and behaviour is otherwise identical.

Test Plan:
- Reset, then req seq -> next cycle pc_source=00, pc_write=1 for exactly 1 cycle; req_ready=0 during that cycle, 1 after.
- beq with alu_zero=1 -> pc_source=01, pc_write=1; beq with alu_zero=0 -> pc_write=0; bne with alu_zero=0 -> pc_write=1.
- Exception exc_code=01, MEM_LAT=1, mem_data=8'h7C -> epc_write at accept+1, mem_rd with vec_addr=8'd254 at +2, vec_target=32'h0000007C, and pc_write with pc_source=10, jump_src_vec=1 at +4.
- MEM_LAT=3 with exc_code=11 -> vec_addr=253, held 3 cycles; pc_write at accept+6; req_valid pulses during the sequence are ignored.
- Reset asserted during EXC_WAIT -> outputs cleared immediately; no pc_write follows; the next seq request is serviced normally.
- With PC_CAUSE_REG_EN: exception exc_code=10 -> cause=2, exc_pending=1; a subsequent rte -> pc_source=11, exc_pending=0, cause=2.
